// File: rtl/des_pkg.sv
// des_pkg: shared constants for the time-multiplexed DES S-box engine.
//   - width constants for the 48-bit block, 6-bit groups, 4-bit S-box outputs, 32-bit result
//   - the eight DES S-box tables and the P permutation table (DES bit numbering)
//   - the engine FSM state type and a P-permutation helper function
package des_pkg;

    localparam int unsigned BLK_W  = 48;
    localparam int unsigned GRP_W  = 6;
    localparam int unsigned SOUT_W = 4;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned N_SBOX = 8;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // SBOX_TAB[s][r] is row r of S(s+1); column c is the nibble c places from the MSB.
    localparam logic [63:0] SBOX_TAB [N_SBOX][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
          64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
          64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
          64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
          64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
          64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
          64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
          64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Output bit i+1 of P takes input bit P_TAB[i] (both 1-based, bit 1 = MSB).
    localparam logic [5:0] P_TAB [RES_W] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic logic [1:RES_W] p_perm(input logic [1:RES_W] x);
        logic [1:RES_W] y;
        for (int i = 0; i < int'(RES_W); i++) begin
            y[i+1] = x[P_TAB[i]];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: combinational lookup of one DES S-box.
//   sel  [2:0] : S-box select, 0 = S1 ... 7 = S8
//   din  [1:6] : 6-bit group, bit 1 = MSB; row = {b1,b6}, column = b2..b5
//   dout [1:4] : 4-bit S-box output, bit 1 = MSB
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0]        sel,
    input  logic [1:GRP_W]    din,
    output logic [1:SOUT_W]   dout
);

    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] row_word;
    logic [5:0]  lsb;

    always_comb begin
        row      = {din[1], din[6]};
        col      = din[2:5];
        row_word = SBOX_TAB[sel][row];
        // Column 0 sits in the top nibble, so the nibble offset is (15 - col) * 4.
        lsb      = {~col, 2'b00};
        dout     = row_word[lsb +: 4];
    end

endmodule

// File: rtl/des_sbox_seq.sv
// des_sbox_seq: time-multiplexed DES S-box substitution with optional P permutation.
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data [1:48] is the post-key-mix block
//   out_valid/out_ready : output handshake; out_data [1:32] holds the registered result
//   busy                : high while S-box steps are being evaluated
// LANES S-boxes are evaluated per cycle, so one block takes 8/LANES cycles.
module des_sbox_seq
    import des_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned P_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:BLK_W]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:RES_W]   out_data,
    output logic             busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
    end

    localparam int unsigned STEPS    = N_SBOX / LANES;
    localparam int unsigned LANE_W   = SOUT_W * LANES;
    localparam int unsigned SHIFT_IN = GRP_W * LANES;

    state_e              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [1:BLK_W]      sreg_q, sreg_d;
    logic [1:RES_W]      acc_q, acc_d;
    logic [1:RES_W]      out_q, out_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [1:LANE_W]     lane_cat;
    logic [1:RES_W]      acc_next;
    logic [1:RES_W]      result;
    logic                last_step;
    logic                accept;

    // Lane l always reads the l-th group from the top of the shift register.
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic [2:0] lane_sel;
        assign lane_sel = 3'(int'(step_q) * int'(LANES) + l);

        des_sbox_lut u_lut (
            .sel  (lane_sel),
            .din  (sreg_q[GRP_W*l+1 +: GRP_W]),
            .dout (lane_cat[SOUT_W*l+1 +: SOUT_W])
        );
    end

    // In DONE the slot frees up in the same cycle the consumer pops.
    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_next  = (acc_q << LANE_W) | RES_W'(lane_cat);
        result    = (P_EN != 0) ? p_perm(acc_next) : acc_next;
        last_step = (step_q == 3'(STEPS - 1));

        state_d = state_q;
        step_d  = step_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        out_d   = out_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = in_data;
                    step_d  = 3'd0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sreg_d = sreg_q << SHIFT_IN;
                acc_d  = acc_next;
                step_d = step_q + 3'd1;
                if (last_step) begin
                    step_d  = 3'd0;
                    out_d   = result;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_d = '0;
                    if (in_valid) begin
                        sreg_d  = in_data;
                        step_d  = 3'd0;
                        acc_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        valid_d = (state_d == StDone);
        busy_d  = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            sreg_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_sbox_seq.sv
// tb_des_sbox_seq: directed self-checking bench for des_sbox_seq.
// Four engines share clock, reset and input stimulus:
//   dut2 (LANES=2,P_EN=0), dutp (LANES=2,P_EN=1), dut8 (LANES=8,P_EN=0), dut1 (LANES=1,P_EN=0).
module tb_des_sbox_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:48] in_data;
    logic        out_ready;

    logic        ir2, ov2, bz2;
    logic [1:32] od2;
    logic        irp, ovp, bzp;
    logic [1:32] odp;
    logic        ir8, ov8, bz8;
    logic [1:32] od8;
    logic        ir1, ov1, bz1;
    logic [1:32] od1;

    int total = 0;
    int bad   = 0;

    des_sbox_seq #(.LANES(2), .P_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(bz2)
    );
    des_sbox_seq #(.LANES(2), .P_EN(1)) dutp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irp), .in_data(in_data),
        .out_valid(ovp), .out_ready(out_ready), .out_data(odp), .busy(bzp)
    );
    des_sbox_seq #(.LANES(8), .P_EN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_data(in_data),
        .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .busy(bz8)
    );
    des_sbox_seq #(.LANES(1), .P_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of run_block: first-valid latency and data per engine.
    int          lat2, lat8, lat1, vcnt2;
    logic [1:32] d2, dp, d8, d1;

    // Pushes one block into idle engines with out_ready=1 and watches 10 edges.
    task automatic run_block(input logic [1:48] blk);
        lat2 = 0; lat8 = 0; lat1 = 0; vcnt2 = 0;
        d2 = '0; dp = '0; d8 = '0; d1 = '0;
        in_data  = blk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ov2) begin
                vcnt2++;
                if (lat2 == 0) begin lat2 = n; d2 = od2; dp = odp; end
            end
            if (ov8 && lat8 == 0) begin lat8 = n; d8 = od8; end
            if (ov1 && lat1 == 0) begin lat1 = n; d1 = od1; end
        end
    endtask

    int          pos [3];
    logic [1:32] r2 [3];
    logic [1:32] rp [3];
    logic        irv [3];
    logic [1:48] blks [3];
    logic [1:32] exp_raw [3];
    logic [1:32] exp_p [3];
    int          nv, nxt;
    logic        acc_now;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", 48'(ov2), 48'd0);
        chk("rst_busy", 48'(bz2), 48'd0);
        chk("rst_in_ready", 48'(ir2), 48'd1);
        chk("rst_out_data", 48'(od2), 48'd0);
        chk("rst_out_data_p", 48'(odp), 48'd0);
        chk("rst_ready_l8_l1", 48'({ir8, ir1, bz8, bz1}), 48'b1100);

        // All-zero block: row 0 column 0 of every S-box
        run_block(48'h0000_0000_0000);
        chk("zero_lat_l2", 48'(lat2), 48'd4);
        chk("zero_lat_l8", 48'(lat8), 48'd1);
        chk("zero_lat_l1", 48'(lat1), 48'd8);
        chk("zero_data_l2", 48'(d2), 48'hEFA72C4D);
        chk("zero_data_p", 48'(dp), 48'hD8D8DBBC);
        chk("zero_data_l8", 48'(d8), 48'hEFA72C4D);
        chk("zero_data_l1", 48'(d1), 48'hEFA72C4D);
        chk("zero_valid_cycles", 48'(vcnt2), 48'd1);
        chk("zero_back_idle", 48'({ir2, bz2, ov2}), 48'b100);

        // All-ones block: row 3 column 15
        run_block(48'hFFFF_FFFF_FFFF);
        chk("ones_lat_l8", 48'(lat8), 48'd1);
        chk("ones_lat_l1", 48'(lat1), 48'd8);
        chk("ones_data_l2", 48'(d2), 48'hD9CE3DCB);
        chk("ones_data_p", 48'(dp), 48'h38DBF9CB);
        chk("ones_data_l8", 48'(d8), 48'hD9CE3DCB);
        chk("ones_data_l1", 48'(d1), 48'hD9CE3DCB);

        // Single-group vectors
        run_block(48'h6C00_0000_0000);
        chk("g0_data_l2", 48'(d2), 48'h5FA72C4D);
        chk("g0_data_p", 48'(dp), 48'hD858D9BE);
        chk("g0_data_l1", 48'(d1), 48'h5FA72C4D);
        run_block(48'h0000_3F00_0000);
        chk("g3_data_l2", 48'(d2), 48'hEFAE2C4D);
        chk("g3_data_l8", 48'(d8), 48'hEFAE2C4D);
        run_block(48'h0000_0000_0021);
        chk("g7_data_l2", 48'(d2), 48'hEFA72C42);
        chk("g7_data_l1", 48'(d1), 48'hEFA72C42);

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        in_data   = 48'h0000_0000_0000;
        in_valid  = 1'b1;
        tick();
        in_data = 48'hFFFF_FFFF_FFFF;
        for (int n = 1; n <= 4; n++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 48'(ov2), 48'd1);
            chk("bp_data", 48'(od2), 48'hEFA72C4D);
            chk("bp_in_ready", 48'(ir2), 48'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follows", 48'(ir2), 48'd1);
        tick();
        chk("bp_pop", 48'({ov2, bz2}), 48'b00);
        chk("bp_pop_data", 48'(od2), 48'd0);
        tick();
        chk("bp_single_pop", 48'({ov2, ir2}), 48'b01);
        for (int n = 0; n < 12; n++) tick();

        // Back-to-back with pop and accept on the same edge
        blks[0] = 48'h0000_0000_0000; exp_raw[0] = 32'hEFA72C4D; exp_p[0] = 32'hD8D8DBBC;
        blks[1] = 48'hFFFF_FFFF_FFFF; exp_raw[1] = 32'hD9CE3DCB; exp_p[1] = 32'h38DBF9CB;
        blks[2] = 48'h6C00_0000_0000; exp_raw[2] = 32'h5FA72C4D; exp_p[2] = 32'hD858D9BE;
        for (int i = 0; i < 3; i++) begin pos[i] = 0; r2[i] = '0; rp[i] = '0; irv[i] = 0; end
        in_data  = blks[0];
        in_valid = 1'b1;
        nxt = 1;
        nv  = 0;
        for (int c = 1; c <= 30 && nv < 3; c++) begin
            acc_now = in_valid && ir2;
            tick();
            if (acc_now) begin
                if (nxt < 3) begin in_data = blks[nxt]; nxt++; end
                else in_valid = 1'b0;
            end
            if (ov2) begin
                pos[nv] = c; r2[nv] = od2; rp[nv] = odp; irv[nv] = ir2;
                nv++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 48'(nv), 48'd3);
        chk("b2b_first_pos", 48'(pos[0]), 48'd5);
        chk("b2b_gap1", 48'(pos[1] - pos[0]), 48'd5);
        chk("b2b_gap2", 48'(pos[2] - pos[1]), 48'd5);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_raw", 48'(r2[i]), 48'(exp_raw[i]));
            chk("b2b_perm", 48'(rp[i]), 48'(exp_p[i]));
            chk("b2b_ready_at_valid", 48'(irv[i]), 48'd1);
        end
        tick();
        chk("b2b_end_idle", 48'({ov2, bz2, ir2}), 48'b001);
        for (int n = 0; n < 20; n++) tick();

        // Reset in the middle of RUN
        in_data  = 48'hFFFF_FFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_run_busy", 48'(bz2), 48'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_run_valid", 48'(ov2), 48'd0);
        chk("rst_run_busy", 48'(bz2), 48'd0);
        chk("rst_run_data", 48'(od2), 48'd0);
        chk("rst_run_ready", 48'(ir2), 48'd1);
        rst_n = 1'b1;
        run_block(48'h0000_0000_0021);
        chk("post_rst_lat", 48'(lat2), 48'd4);
        chk("post_rst_data", 48'(d2), 48'hEFA72C42);
        chk("post_rst_data_l8", 48'(d8), 48'hEFA72C42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
